// File: rtl/ram_responder.sv
// Byte-addressable big-endian memory slave with fixed-latency handshake.
// Accepts one access per MOV pulse, answers with MOC/err after LATENCY cycles.
module ram_responder #(
    parameter int DEPTH_BYTES = 512,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] MAR,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        err
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   data_reg;
    logic          rw_reg;
    logic          sign_reg;
    logic [1:0]    size_reg;

    // Operation fields: live inputs in IDLE (so LATENCY=1 can finish on the
    // accepting edge), captured copies afterwards.
    logic          is_idle;
    logic [31:0]   op_addr;
    logic [31:0]   op_data;
    logic          op_rw;
    logic          op_sign;
    logic [1:0]    op_size;

    assign is_idle = (state_reg == IDLE);
    assign op_addr = is_idle ? MAR    : addr_reg;
    assign op_data = is_idle ? DataIn : data_reg;
    assign op_rw   = is_idle ? RW     : rw_reg;
    assign op_sign = is_idle ? sign   : sign_reg;
    assign op_size = is_idle ? size   : size_reg;

    logic accept;
    logic finish;

    assign accept = is_idle && MOV;
    assign finish = (accept && (LATENCY == 1)) ||
                    ((state_reg == BUSY) && (cnt_reg == '0));

    // Fault detection; the end address is formed in 33 bits so it never wraps.
    logic [32:0] width;
    logic [32:0] end_addr;
    logic        range_fault;
    logic        align_fault;
    logic        fault;

    always_comb begin
        width = 33'd4;
        case (op_size)
            2'b00:   width = 33'd1;
            2'b01:   width = 33'd2;
            default: width = 33'd4;
        endcase
    end

    assign end_addr    = {1'b0, op_addr} + width - 33'd1;
    assign range_fault = (end_addr >= 33'(DEPTH_BYTES));
    assign align_fault = (op_size == 2'b11) ||
                         ((op_size == 2'b01) && op_addr[0]) ||
                         ((op_size == 2'b10) && (op_addr[1:0] != 2'b00));
    assign fault       = range_fault || align_fault;

    logic          commit;
    logic [1:0]    off;
    logic [AW-3:0] widx;
    logic [7:0]    rd_lane [4];
    logic [31:0]   rd_word;

    assign commit = finish && !fault && !op_rw && reset;
    assign off    = op_addr[1:0];
    assign widx   = op_addr[AW-1:2];

    // Lane gi holds byte offset gi, i.e. bits [31-8*gi -: 8] of a word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [WORDS];
            logic       we;
            logic [7:0] wd;

            always_comb begin
                we = 1'b0;
                wd = op_data[7:0];
                case (op_size)
                    2'b00: begin
                        we = (off == 2'(gi));
                        wd = op_data[7:0];
                    end
                    2'b01: begin
                        we = (off[1] == 1'(gi / 2));
                        wd = ((gi % 2) == 0) ? op_data[15:8] : op_data[7:0];
                    end
                    2'b10: begin
                        we = 1'b1;
                        wd = op_data[31-8*gi -: 8];
                    end
                    default: begin
                        we = 1'b0;
                        wd = op_data[7:0];
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (commit && we) begin
                    mem[widx] <= wd;
                end
            end

            assign rd_lane[gi] = mem[widx];
        end
    endgenerate

    assign rd_word = {rd_lane[0], rd_lane[1], rd_lane[2], rd_lane[3]};

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] rd_data;

    always_comb begin
        byte_sel = rd_word[31:24];
        case (off)
            2'd0:    byte_sel = rd_word[31:24];
            2'd1:    byte_sel = rd_word[23:16];
            2'd2:    byte_sel = rd_word[15:8];
            default: byte_sel = rd_word[7:0];
        endcase
        half_sel = off[1] ? rd_word[15:0] : rd_word[31:16];

        rd_data = '0;
        case (op_size)
            2'b00:   rd_data = {{24{op_sign & byte_sel[7]}}, byte_sel};
            2'b01:   rd_data = {{16{op_sign & half_sel[15]}}, half_sel};
            2'b10:   rd_data = rd_word;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            rw_reg    <= 1'b0;
            sign_reg  <= 1'b0;
            size_reg  <= 2'b00;
            DataOut   <= '0;
            MOC       <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (MOV) begin
                        addr_reg  <= MAR;
                        data_reg  <= DataIn;
                        rw_reg    <= RW;
                        sign_reg  <= sign;
                        size_reg  <= size;
                        cnt_reg   <= CNT_LOAD;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    // MOV still high keeps us here, so no second access starts.
                    if (!MOV) begin
                        state_reg <= IDLE;
                        MOC       <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    MOC       <= 1'b0;
                    err       <= 1'b0;
                end
            endcase

            if (finish) begin
                state_reg <= DONE;
                MOC       <= 1'b1;
                err       <= fault;
                if (op_rw) begin
                    DataOut <= fault ? 32'd0 : rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: directed accesses push expectations,
// a negedge monitor pops one entry per MOC rising edge.
module tb_ram_responder;

    localparam int DEPTH = 512;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic        MOV;
    logic        RW;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] MAR;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        err;

    ram_responder #(
        .DEPTH_BYTES(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .MOV    (MOV),
        .RW     (RW),
        .size   (size),
        .sign   (sign),
        .MAR    (MAR),
        .DataIn (DataIn),
        .DataOut(DataOut),
        .MOC    (MOC),
        .err    (err)
    );

    typedef struct {
        logic        is_read;
        logic        e_err;
        logic [31:0] e_data;
        int          issue;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   txn   = 0;
    logic moc_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per MOC rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!MOC && err) begin
            tests++;
            fails++;
            $display("FAIL err_without_moc: err=%0b while MOC=0", err);
        end
        if (MOC && !moc_prev) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_moc: MOC rose at cycle %0d with no request pending", cyc);
            end else begin
                e = sb.pop_front();
                txn++;
                $display("[TB] txn %0d rw=%0b err=%0b DataOut=%08h latency=%0d",
                         txn, e.is_read, err, DataOut, cyc - e.issue);
                chk("err", {31'd0, err}, {31'd0, e.e_err});
                chk("latency", cyc - e.issue, LAT);
                if (e.is_read) chk("read_data", DataOut, e.e_data);
            end
        end
        moc_prev = MOC;
    end

    task automatic wait_moc(input logic level);
        int n = 0;
        while (MOC !== level && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (MOC !== level) begin
            tests++;
            fails++;
            $display("FAIL moc_timeout: MOC stuck at %0b, wanted %0b", MOC, level);
        end
    endtask

    task automatic op(input logic rw, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] din,
                      input logic e_err, input logic [31:0] e_data);
        exp_t e;
        @(negedge clk);
        MOV = 1'b1; RW = rw; size = sz; sign = sg; MAR = addr; DataIn = din;
        @(posedge clk);
        #1;
        e.is_read = rw; e.e_err = e_err; e.e_data = e_data; e.issue = cyc;
        sb.push_back(e);
        @(negedge clk);
        // Scramble inputs: the captured copies must be used.
        MOV = 1'b0; MAR = 32'hFFFF_FFFF; DataIn = 32'h5A5A_5A5A; size = 2'b11; RW = ~rw; sign = ~sg;
        wait_moc(1'b1);
        wait_moc(1'b0);
    endtask

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    initial begin
        exp_t e;
        reset = 1'b0; MOV = 1'b0; RW = 1'b0; size = 2'b00; sign = 1'b0;
        MAR = '0; DataIn = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_moc", {31'd0, MOC}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_dataout", DataOut, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic word, byte and sign-extension behaviour
        op(WR, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        op(RD, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
        op(WR, 2'b00, 1'b0, 32'h11, 32'hAAAAAA80, 1'b0, 32'h0);
        op(RD, 2'b00, 1'b1, 32'h11, 32'h0,        1'b0, 32'hFFFFFF80);
        op(RD, 2'b00, 1'b0, 32'h11, 32'h0,        1'b0, 32'h00000080);
        op(RD, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDE80BEEF);

        // Alignment and illegal-size faults
        op(WR, 2'b01, 1'b0, 32'h13, 32'h0000FFFF, 1'b1, 32'h0);
        op(RD, 2'b10, 1'b0, 32'h12, 32'h0,        1'b1, 32'h0);
        op(RD, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDE80BEEF);
        op(RD, 2'b11, 1'b0, 32'h10, 32'h0,        1'b1, 32'h0);

        // Range faults at the top of memory, no wrap to address 0
        op(WR, 2'b10, 1'b0, 32'h0,   32'h11223344, 1'b0, 32'h0);
        op(RD, 2'b10, 1'b0, DEPTH - 2, 32'h0,      1'b1, 32'h0);
        op(WR, 2'b10, 1'b0, DEPTH,   32'hCAFEF00D, 1'b1, 32'h0);
        op(RD, 2'b10, 1'b0, 32'h00010010, 32'h0,   1'b1, 32'h0);
        op(RD, 2'b10, 1'b0, 32'h0,   32'h0,        1'b0, 32'h11223344);
        op(WR, 2'b10, 1'b0, 32'h1FC, 32'h55667788, 1'b0, 32'h0);
        op(WR, 2'b00, 1'b0, 32'h1FF, 32'h0000007F, 1'b0, 32'h0);
        op(RD, 2'b10, 1'b0, 32'h1FC, 32'h0,        1'b0, 32'h5566777F);
        op(RD, 2'b01, 1'b1, 32'h1FE, 32'h0,        1'b0, 32'h0000777F);
        op(RD, 2'b00, 1'b1, DEPTH,   32'h0,        1'b1, 32'h0);

        // Halfword lanes
        op(WR, 2'b10, 1'b0, 32'h24, 32'h0,        1'b0, 32'h0);
        op(WR, 2'b01, 1'b0, 32'h26, 32'hFFFF8001, 1'b0, 32'h0);
        op(RD, 2'b10, 1'b0, 32'h24, 32'h0,        1'b0, 32'h00008001);
        op(RD, 2'b01, 1'b1, 32'h26, 32'h0,        1'b0, 32'hFFFF8001);
        op(RD, 2'b01, 1'b0, 32'h26, 32'h0,        1'b0, 32'h00008001);

        // Reset during BUSY aborts the write
        op(WR, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        MOV = 1'b1; RW = WR; size = 2'b10; MAR = 32'h20; DataIn = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        MOV = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_moc", {31'd0, MOC}, 32'd0);
        chk("abort_dataout", DataOut, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        op(RD, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);

        // MOV held high for 6 edges: one MOC, held until MOV falls
        @(negedge clk);
        MOV = 1'b1; RW = RD; size = 2'b10; sign = 1'b0; MAR = 32'h10;
        @(posedge clk);
        #1;
        e.is_read = 1'b1; e.e_err = 1'b0; e.e_data = 32'hDE80BEEF; e.issue = cyc;
        sb.push_back(e);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("hold_moc_high", {31'd0, MOC}, 32'd1);
        MOV = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_moc_drop", {31'd0, MOC}, 32'd0);
        op(RD, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'hFFFFFFDE);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
